// File: rtl/cell_seq_pkg.sv
// Shared types and constants for the cell array sequencer.
package cell_seq_pkg;

    localparam int ROWS = 12;
    localparam int BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2
    } cell_seq_state_t;

    typedef logic [ROWS-1:0] row_mask_t;

    // Larger of two integers; sizes the phase counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cell_phase_timer.sv
// Loadable down-counter timing one array phase. Loading N-1 on phase entry
// makes done rise in the Nth (last) cycle of that phase. It stops at zero.
module cell_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    // Reload on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CW{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (count != {CW{1'b0}}) begin
            count <= count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    assign done = (count == {CW{1'b0}});

endmodule

// File: rtl/cell_array_sequencer.sv
// Drives a 12-row precharged wired-OR cell array: precharge, evaluate with
// the requested rows driven, then sample the sensed rows into a result slot.
module cell_array_sequencer
    import cell_seq_pkg::*;
#(
    parameter int        WIDTH     = 1,
    parameter int        PRE_CYC   = 1,
    parameter int        EVAL_CYC  = 2,
    parameter logic [11:0] PRECHARGE = 12'hfff
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ROWS-1:0]          req_mask,
    input  logic [ROWS*WIDTH*8-1:0]  req_data,
    output logic                     clk_phase,
    output logic [ROWS-1:0]          drv_en,
    output logic [ROWS*WIDTH*8-1:0]  drv_data,
    input  logic [ROWS*WIDTH*8-1:0]  io_sense,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*WIDTH*8-1:0]  res_rows,
    output logic [WIDTH*8-1:0]       res_or
);

    localparam int DW = WIDTH * BYTE;
    localparam int AW = ROWS * DW;
    localparam int CW = $clog2(max2(PRE_CYC, EVAL_CYC) + 1);
    localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYC - 1);

    cell_seq_state_t state, state_next;
    row_mask_t       mask_r;
    logic [AW-1:0]   data_r;
    logic [AW-1:0]   masked_data;
    logic [DW-1:0]   sense_or;
    logic            accept;
    logic            timer_load;
    logic [CW-1:0]   timer_val;
    logic            timer_done;
    logic            capture;

    assign req_ready = (state == IDLE) & (~res_valid | res_ready);
    assign accept    = req_valid & req_ready;

    cell_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next-state logic; the timer is reloaded on every phase entry.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = {CW{1'b0}};
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PRE;
                    timer_load = 1'b1;
                    timer_val  = PRE_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            PRE: begin
                if (timer_done) begin
                    state_next = EVAL;
                    timer_load = 1'b1;
                    timer_val  = EVAL_LOAD;
                end else begin
                    state_next = PRE;
                end
            end
            EVAL: begin
                if (timer_done) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end else begin
                    state_next = EVAL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the operand set on accept; non-precharged rows are dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r <= {ROWS{1'b0}};
            data_r <= {AW{1'b0}};
        end else if (accept) begin
            mask_r <= req_mask & PRECHARGE;
            data_r <= req_data;
        end else begin
            mask_r <= mask_r;
            data_r <= data_r;
        end
    end

    // Zero the data of rows that are not driven, and OR the sensed rows.
    always_comb begin
        masked_data = {AW{1'b0}};
        sense_or    = {DW{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            if (mask_r[i]) begin
                masked_data[i*DW +: DW] = data_r[i*DW +: DW];
            end else begin
                masked_data[i*DW +: DW] = {DW{1'b0}};
            end
            sense_or = sense_or | io_sense[i*DW +: DW];
        end
    end

    // Phase and drivers are registered so they are 1/active exactly in EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_phase <= 1'b0;
            drv_en    <= {ROWS{1'b0}};
            drv_data  <= {AW{1'b0}};
        end else if (state_next == EVAL) begin
            clk_phase <= 1'b1;
            drv_en    <= mask_r;
            drv_data  <= masked_data;
        end else begin
            clk_phase <= 1'b0;
            drv_en    <= {ROWS{1'b0}};
            drv_data  <= {AW{1'b0}};
        end
    end

    // One-entry result slot: fill at the end of EVAL, empty on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_rows  <= {AW{1'b0}};
            res_or    <= {DW{1'b0}};
        end else if (capture) begin
            res_valid <= 1'b1;
            res_rows  <= io_sense;
            res_or    <= sense_or;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            res_rows  <= res_rows;
            res_or    <= res_or;
        end else begin
            res_valid <= res_valid;
            res_rows  <= res_rows;
            res_or    <= res_or;
        end
    end

endmodule
